ps2_host_tx: RTL

Host-to-device PS/2 transmitter: the sending end of the keyboard link whose device-to-host side is decoded by the keyboard receiver. It takes one command byte (e.g. 0xED set-LEDs, 0xFF reset), inhibits the bus, issues a request-to-send, shifts out the byte with odd parity and a stop bit on device-generated clocks, then checks the device's acknowledge bit. It sits beside the keyboard receiver on the shared PS2_clk/PS2_data pins, which are open-drain, and drives `busy` so the receiver can ignore the clocks generated during a host frame.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Definitions shared by the PS/2 host transmitter and the keyboard receiver:
// transmitter states, frame geometry and the odd-parity rule.
package ps2_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_EDGES = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } ps2TxState_e;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic oddParity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge detector on the
// synchronized level. Shared by the host transmitter and the keyboard receiver.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts a
// command byte out on device clocks and checks the device acknowledge bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 ps2_clk_in,
  input  logic                 ps2_data_in,
  output logic                 ps2_clk_oe,
  output logic                 ps2_data_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SHIFT_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] INHIBIT_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_DATA_EDGE = 4'(FRAME_EDGES - 2);

  logic clkSync;
  logic clkFall;
  logic dataSync;
  logic dataFallUnused;

  ps2_sync u_clkSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ps2_clk_in),
    .level_o (clkSync),
    .fall_o  (clkFall)
  );

  // Only the level of the data line matters here; its edges carry no meaning.
  ps2_sync u_dataSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ps2_data_in),
    .level_o (dataSync),
    .fall_o  (dataFallUnused)
  );

  ps2TxState_e        state_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [3:0]         edgeCnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               clkOe_q;
  logic               dataOe_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               ready_q;

  logic [SHIFT_W-1:0] frame_d;
  logic [CNT_W-1:0]   cntInc_d;
  logic               accept_d;
  logic               timeout_d;

  // Shift register is {stop, parity, data} and leaves LSB first.
  assign frame_d   = {1'b1, oddParity(tx_data), tx_data};
  assign cntInc_d  = cnt_q + 1'b1;
  assign accept_d  = tx_valid & ready_q;
  assign timeout_d = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      edgeCnt_q <= '0;
      cnt_q     <= '0;
      clkOe_q   <= 1'b0;
      dataOe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          if (accept_d) begin
            shift_q <= frame_d;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            clkOe_q <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_INHIBIT;
          end else begin
            ready_q <= 1'b1;
          end
        end

        S_INHIBIT: begin
          if (cnt_q == INHIBIT_LAST) begin
            dataOe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_START;
          end else begin
            cnt_q <= cntInc_d;
          end
        end

        // Start bit (data low) is already on the line when the clock is released.
        S_START: begin
          clkOe_q   <= 1'b0;
          cnt_q     <= '0;
          edgeCnt_q <= '0;
          state_q   <= S_BITS;
        end

        S_BITS: begin
          if (clkFall) begin
            cnt_q     <= '0;
            dataOe_q  <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[SHIFT_W-1:1]};
            edgeCnt_q <= edgeCnt_q + 4'd1;
            if (edgeCnt_q == LAST_DATA_EDGE) begin
              state_q <= S_ACK;
            end
          end else if (timeout_d) begin
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cntInc_d;
          end
        end

        S_ACK: begin
          if (clkFall) begin
            err_q   <= dataSync;
            cnt_q   <= '0;
            state_q <= S_WAIT_IDLE;
          end else if (timeout_d) begin
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cntInc_d;
          end
        end

        // The device releases both lines once the acknowledge clock is over.
        S_WAIT_IDLE: begin
          if (clkSync && dataSync) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clkOe_q;
  assign ps2_data_oe = dataOe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
